// File: rtl/ysyx_22041211_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_wbu -- write-back unit of the multicycle core.
//
// Takes one retiring instruction from the LSU over a valid/ready handshake and
// walks it through three states:
//   WB_IDLE  : wb_ready_o high; a valid LSU result is captured.
//   WB_WRITE : GPR / CSR write ports are driven for exactly one cycle.
//   WB_DONE  : wb_valid_o / commit_pc_o are presented to the IFU until it
//              takes the commit; the retire counters advance at that edge.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   lsu_valid_i       LSU result valid      wb_ready_o   WBU can accept
//   wd_i, wreg_i,     GPR write request / index / data
//   wdata_i
//   csr_wen_i,        CSR write request / address / data
//   csr_addr_i, csr_wdata_i
//   memory_inst_i     instruction was a load/store
//   pc_i              PC of the retiring instruction
//   ifu_ready_i       IFU ready to take the commit
//   reg_wen_o, reg_waddr_o, reg_wdata_o     register-file write port
//   csr_wen_o, csr_addr_o, csr_wdata_o      CSR write port
//   wb_valid_o, commit_pc_o                 commit to IFU
//   retire_cnt_o, mem_inst_cnt_o            retired / load-store counters
// ----------------------------------------------------------------------------
module ysyx_22041211_wbu #(
    parameter int DATA_LEN = 32,
    parameter int CNT_LEN  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    output logic                wb_ready_o,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic                csr_wen_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    input  logic                memory_inst_i,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic                ifu_ready_i,
    output logic                reg_wen_o,
    output logic [4:0]          reg_waddr_o,
    output logic [DATA_LEN-1:0] reg_wdata_o,
    output logic                csr_wen_o,
    output logic [11:0]         csr_addr_o,
    output logic [DATA_LEN-1:0] csr_wdata_o,
    output logic                wb_valid_o,
    output logic [DATA_LEN-1:0] commit_pc_o,
    output logic [CNT_LEN-1:0]  retire_cnt_o,
    output logic [31:0]         mem_inst_cnt_o
);

    typedef enum logic [1:0] {
        WB_IDLE  = 2'b00,
        WB_WRITE = 2'b01,
        WB_DONE  = 2'b10
    } wb_state_t;

    wb_state_t state;
    logic      ready_q;
    logic      mem_inst_q;

    // ready_q mirrors "state == WB_IDLE"; it is forced low while rst is held
    // so the LSU never sees a ready during reset.
    assign wb_ready_o = ready_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WB_IDLE;
            ready_q        <= 1'b1;
            reg_wen_o      <= 1'b0;
            reg_waddr_o    <= '0;
            reg_wdata_o    <= '0;
            csr_wen_o      <= 1'b0;
            csr_addr_o     <= '0;
            csr_wdata_o    <= '0;
            wb_valid_o     <= 1'b0;
            commit_pc_o    <= '0;
            mem_inst_q     <= 1'b0;
            retire_cnt_o   <= '0;
            mem_inst_cnt_o <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (lsu_valid_i && ready_q) begin
                        // Enables are registered here so they are high for
                        // exactly the WB_WRITE cycle; x0 writes are dropped.
                        reg_wen_o   <= wd_i & (wreg_i != 5'd0);
                        reg_waddr_o <= wreg_i;
                        reg_wdata_o <= wdata_i;
                        csr_wen_o   <= csr_wen_i;
                        csr_addr_o  <= csr_addr_i;
                        csr_wdata_o <= csr_wdata_i;
                        commit_pc_o <= pc_i;
                        mem_inst_q  <= memory_inst_i;
                        ready_q     <= 1'b0;
                        state       <= WB_WRITE;
                    end
                end
                WB_WRITE: begin
                    reg_wen_o  <= 1'b0;
                    csr_wen_o  <= 1'b0;
                    wb_valid_o <= 1'b1;
                    state      <= WB_DONE;
                end
                WB_DONE: begin
                    if (ifu_ready_i) begin
                        wb_valid_o     <= 1'b0;
                        ready_q        <= 1'b1;
                        retire_cnt_o   <= retire_cnt_o + CNT_LEN'(1);
                        mem_inst_cnt_o <= mem_inst_cnt_o + {31'd0, mem_inst_q};
                        state          <= WB_IDLE;
                    end
                end
                default: begin
                    // Illegal encoding: drop everything and go back to idle.
                    reg_wen_o  <= 1'b0;
                    csr_wen_o  <= 1'b0;
                    wb_valid_o <= 1'b0;
                    ready_q    <= 1'b1;
                    state      <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
module tb_ysyx_22041211_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid_i;
    logic        wb_ready_o;
    logic        wd_i;
    logic [4:0]  wreg_i;
    logic [31:0] wdata_i;
    logic        csr_wen_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        memory_inst_i;
    logic [31:0] pc_i;
    logic        ifu_ready_i;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        csr_wen_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        wb_valid_o;
    logic [31:0] commit_pc_o;
    logic [63:0] retire_cnt_o;
    logic [31:0] mem_inst_cnt_o;

    ysyx_22041211_wbu #(.DATA_LEN(32), .CNT_LEN(64)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid_i(lsu_valid_i), .wb_ready_o(wb_ready_o),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .memory_inst_i(memory_inst_i), .pc_i(pc_i), .ifu_ready_i(ifu_ready_i),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .wb_valid_o(wb_valid_o), .commit_pc_o(commit_pc_o),
        .retire_cnt_o(retire_cnt_o), .mem_inst_cnt_o(mem_inst_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cw;
        logic [11:0] ca;
        logic [31:0] cd;
        int          c;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] ret;
        logic [31:0] mem;
        int          c;
    } cm_t;

    wr_t wq[$];
    cm_t cq[$];

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_ret = 0;
    logic [31:0] exp_mem = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops write expectations on every enable pulse and commit
    // expectations on every rising wb_valid_o; checks counters on commit exit.
    initial begin : monitor
        logic prev_v;
        cm_t  cur;
        prev_v = 1'b0;
        cur = '{pc: 0, ret: 0, mem: 0, c: 0};
        forever begin
            @(negedge clk);
            if (reg_wen_o === 1'b1 || csr_wen_o === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {62'd0, reg_wen_o, csr_wen_o}, 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_cycle", 64'(cyc - e.c), 64'd0);
                    chk("reg_wen", {63'd0, reg_wen_o}, {63'd0, e.rw});
                    chk("csr_wen", {63'd0, csr_wen_o}, {63'd0, e.cw});
                    if (e.rw) begin
                        chk("reg_waddr", {59'd0, reg_waddr_o}, {59'd0, e.wa});
                        chk("reg_wdata", {32'd0, reg_wdata_o}, {32'd0, e.wd});
                    end
                    if (e.cw) begin
                        chk("csr_addr", {52'd0, csr_addr_o}, {52'd0, e.ca});
                        chk("csr_wdata", {32'd0, csr_wdata_o}, {32'd0, e.cd});
                    end
                end
            end
            if (rst !== 1'b1) begin
                if (wb_valid_o === 1'b1 && !prev_v) begin
                    if (cq.size() == 0) begin
                        chk("unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        cur = cq.pop_front();
                        chk("commit_cycle", 64'(cyc - cur.c), 64'd1);
                        chk("commit_pc", {32'd0, commit_pc_o}, {32'd0, cur.pc});
                        chk("ready_in_done", {63'd0, wb_ready_o}, 64'd0);
                    end
                end else if (wb_valid_o === 1'b0 && prev_v) begin
                    chk("retire_cnt", retire_cnt_o, cur.ret);
                    chk("mem_inst_cnt", {32'd0, mem_inst_cnt_o}, {32'd0, cur.mem});
                end
            end
            prev_v = (wb_valid_o === 1'b1) && (rst !== 1'b1);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (wb_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (wb_ready_o !== 1'b1) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic cwen, input logic [11:0] caddr, input logic [31:0] cdata,
                         input logic mem, input logic [31:0] pc, input logic commit);
        wr_t w;
        cm_t c;
        wait_ready();
        lsu_valid_i = 1'b1; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        csr_wen_i = cwen; csr_addr_i = caddr; csr_wdata_i = cdata;
        memory_inst_i = mem; pc_i = pc;
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b0;
        w.rw = wd && (wreg != 5'd0);
        w.wa = wreg; w.wd = wdata; w.cw = cwen; w.ca = caddr; w.cd = cdata; w.c = cyc;
        if (w.rw || w.cw) wq.push_back(w);
        if (commit) begin
            exp_ret = exp_ret + 64'd1;
            exp_mem = exp_mem + {31'd0, mem};
            c.pc = pc; c.ret = exp_ret; c.mem = exp_mem; c.c = cyc;
            cq.push_back(c);
        end
    endtask

    initial begin
        rst = 1'b1; lsu_valid_i = 1'b0; wd_i = 1'b0; wreg_i = '0; wdata_i = '0;
        csr_wen_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; memory_inst_i = 1'b0;
        pc_i = '0; ifu_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'd0, wb_ready_o}, 64'd0);
        chk("rst_reg_wen", {63'd0, reg_wen_o}, 64'd0);
        chk("rst_valid", {63'd0, wb_valid_o}, 64'd0);
        chk("rst_retire", retire_cnt_o, 64'd0);
        chk("rst_mem", {32'd0, mem_inst_cnt_o}, 64'd0);
        chk("rst_pc", {32'd0, commit_pc_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, wb_ready_o}, 64'd1);

        // single ALU op
        issue(1'b1, 5'd5, 32'h0000_1234, 1'b0, 12'h0, 32'h0, 1'b0, 32'h8000_0000, 1'b1);
        // x0 write suppressed, still commits
        issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 12'h0, 32'h0, 1'b0, 32'h8000_0004, 1'b1);
        // csrrw: GPR and CSR in the same cycle
        issue(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 12'h305, 32'h8000_0000, 1'b0, 32'h8000_0008, 1'b1);

        // IFU backpressure with a stray LSU request that must be ignored
        wait_ready();
        ifu_ready_i = 1'b0;
        issue(1'b1, 5'd3, 32'h0000_0033, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_000C, 1'b1);
        @(posedge clk); #1;
        lsu_valid_i = 1'b1; wd_i = 1'b1; wreg_i = 5'd9; wdata_i = 32'hDEAD_BEEF;
        pc_i = 32'hDEAD_0000; memory_inst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, wb_valid_o}, 64'd1);
            chk("bp_ready", {63'd0, wb_ready_o}, 64'd0);
            chk("bp_retire", retire_cnt_o, exp_ret - 64'd1);
        end
        @(posedge clk); #1;
        lsu_valid_i = 1'b0;
        ifu_ready_i = 1'b1;

        // back-to-back load counting
        issue(1'b1, 5'd1, 32'h0000_0001, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0010, 1'b1);
        issue(1'b1, 5'd2, 32'h0000_0002, 1'b0, 12'h0, 32'h0, 1'b0, 32'h8000_0014, 1'b1);
        issue(1'b0, 5'd4, 32'h0000_0004, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0018, 1'b1);
        wait_ready();
        chk("final_retire", retire_cnt_o, 64'd7);
        chk("final_mem", {32'd0, mem_inst_cnt_o}, 64'd3);

        // reset while in WB_WRITE discards the instruction
        issue(1'b1, 5'd7, 32'h0000_0077, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_001C, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_reg_wen", {63'd0, reg_wen_o}, 64'd0);
        chk("mid_rst_valid", {63'd0, wb_valid_o}, 64'd0);
        chk("mid_rst_retire", retire_cnt_o, 64'd0);
        chk("mid_rst_ready", {63'd0, wb_ready_o}, 64'd0);
        exp_ret = 0;
        exp_mem = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, wb_ready_o}, 64'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_valid", {63'd0, wb_valid_o}, 64'd0);

        // one more instruction after the mid-op reset
        issue(1'b1, 5'd31, 32'h1357_9BDF, 1'b1, 12'h341, 32'h0000_0100, 1'b0, 32'h8000_0020, 1'b1);
        wait_ready();
        chk("last_retire", retire_cnt_o, 64'd1);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("cq_empty", 64'(cq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
